fwd_hazard_scoreboard: RTL and testbench
========================================

# fwd_hazard_scoreboard

Parametrised forwarding and hazard unit for the in-order pipeline. It tracks in-flight register writes per architectural register with an age/latency scoreboard. For the instruction in ID it decides, per source operand, whether to stall or which downstream stage to forward from. It delivers registered forwarding selects aligned to the EX-stage operand muxes, generalising fixed two-operand MEM/WB forwarding to NUM_SRC operands, NUM_FWD forwarding stages and multi-cycle producers (loads).

## Interface
- ADDR_W, 5, register address width
- NUM_REGS, 32, architectural registers (2**ADDR_W)
- NUM_SRC, 2, source operands per instruction
- NUM_FWD, 2, forwarding stages after EX (1 = EX/MEM reg, 2 = MEM/WB reg, ...)
- SEL_W, $clog2(NUM_FWD+1), forwarding select width
- LAT_W, $clog2(NUM_FWD+1), issue latency width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- issue_valid  in  1  instruction moves ID→EX this cycle
- issue_we  in  1  issued instruction writes a register
- issue_rd  in  ADDR_W  its destination
- issue_lat  in  LAT_W  cycles after issue until result sits in a forwardable stage (ALU 1, load 2)
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  NUM_SRC*ADDR_W  ID source registers, operand i at [i*ADDR_W +: ADDR_W]
- id_rs_used  in  NUM_SRC  operand i actually read
- flush  in  1  pipeline redirect/exception
- stall  out  1  combinational; hold ID, inject bubble into EX
- ex_fwd_sel  out  NUM_SRC*SEL_W  registered; 0 = register file, k = stage k

## Operation
- Scoreboard entry per register r≠0: valid, age (1..NUM_FWD), lat (1..NUM_FWD).
- Issue (issue_valid & issue_we & issue_rd≠0): entry[rd] ← {1, age 1, lat clamp(issue_lat)}. Clamp: 0→1, >NUM_FWD→NUM_FWD. Overwrites any older entry (youngest wins).
- Every other valid entry: age<NUM_FWD → age+1; age==NUM_FWD → valid cleared (value in register file, write-before-read).
- Per operand i, when id_valid & id_rs_used[i] & rs≠0:
  - Producer = same-cycle issue matching rs (a=0, its lat), else valid entry[rs] (a, lat); else none.
  - n = a+1 (producer age when consumer reaches EX).
  - none or n>NUM_FWD → sel 0.
  - n<lat → hazard.
  - Else sel n.
- stall = OR of hazards.
- ex_fwd_sel next: flush or stall or !id_valid → all 0; else computed selects.
- Register 0 never recorded, never forwarded.

## Timing
- Reset: all entries invalid, ex_fwd_sel=0, stall=0 (no id_valid), counter 0.
- stall: zero-latency combinational from id_* and issue_*.
- ex_fwd_sel: one cycle after ID evaluation, valid when that instruction is in EX.
- Flush has priority: clears all entries and ex_fwd_sel. Same-cycle issue is discarded.
- Reset mid-operation: immediate asynchronous clear. No partial state survives.
- Issue and retire of the same rd in one cycle: issue wins.
- Stall cycles: caller drives issue_valid=0. Existing entries keep ageing, so a load hazard resolves after lat-1 stall cycles.

## Configuration
- FWD_STALL_CNT_EN defined: adds output stall_cnt (32 bits), incremented each cycle stall=1, saturates at 2^32-1, cleared by reset only (not flush).
- Undefined: no port, no counter logic.

## Structure
- Package fwd_pkg:
  - SEL_RF = 0
  - Typedef sb_entry_t {valid, age, lat}
  - Latency-clamp function
- Sub-module fwd_src_resolve:
  - One instance per operand (generate loop).
  - Inputs: rs, used, scoreboard read, issue bypass.
  - Outputs: hazard, sel.
- Top: scoreboard array, ageing, flush, output registers, optional counter.

## Test plan
- ALU chain: issue rd=5 lat=1 at t, ID rs0=5 at t → stall=0; ex_fwd_sel[0]=1 at t+1.
- Load-use: issue rd=7 lat=2 at t, ID rs1=7 → stall=1 at t, ex_fwd_sel=0 at t+1. Then stall=0 at t+1, ex_fwd_sel[1]=2 at t+2.
- Retire: issue rd=3 lat=1 at t, consumer of rs=3 at t+2 (age 2, n=3) → sel 0, entry invalid at t+3.
- Youngest wins: issue rd=4 lat=2 at t, rd=4 lat=1 at t+1, consumer at t+1 → stall=0, sel=1 at t+2.
- rs=0 after issue rd=0, or id_rs_used=0 → stall=0, sel=0.
- Flush at t with entries rd=9,10 valid and issue rd=11 → consumers of 9/10/11 at t+1 get sel 0, stall 0. Same scenario with rst_n pulsed mid-cycle → identical.

Source files
------------

// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared types and helpers for the forwarding/hazard scoreboard.
// Entry fields are fixed-width so one typedef serves every NUM_FWD up to 255.
package fwd_pkg;

  localparam int unsigned SEL_RF  = 0;
  localparam int unsigned FIELD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [FIELD_W-1:0] age;
    logic [FIELD_W-1:0] lat;
  } sb_entry_t;

  function automatic logic [FIELD_W-1:0] clamp_lat(input logic [FIELD_W-1:0] lat,
                                                   input int unsigned num_fwd);
    if (lat == '0) begin
      return FIELD_W'(1);
    end else if (32'(lat) > num_fwd) begin
      return FIELD_W'(num_fwd);
    end
    return lat;
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_src_resolve.sv
// Per-operand producer lookup: picks the youngest in-flight writer of rs and
// decides between stall, forward from stage n, or register file.
module fwd_src_resolve
  import fwd_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic [ADDR_W-1:0]  rs,
  input  logic               used,
  input  sb_entry_t          ent,
  input  logic               iss_hit,
  input  logic [FIELD_W-1:0] iss_lat,
  output logic               hazard,
  output logic [SEL_W-1:0]   sel
);

  logic               have;
  logic [FIELD_W-1:0] age;
  logic [FIELD_W-1:0] lat;
  logic [FIELD_W:0]   n;

  always_comb begin
    have   = 1'b0;
    age    = '0;
    lat    = '0;
    hazard = 1'b0;
    sel    = SEL_W'(SEL_RF);
    if (used && rs != '0) begin
      if (iss_hit) begin
        have = 1'b1;
        lat  = iss_lat;
      end else if (ent.valid) begin
        have = 1'b1;
        age  = ent.age;
        lat  = ent.lat;
      end
    end
    // n is the producer's age at the moment this consumer occupies EX
    n = {1'b0, age} + 1'b1;
    if (have && n <= (FIELD_W + 1)'(NUM_FWD)) begin
      if (n < {1'b0, lat}) begin
        hazard = 1'b1;
      end else begin
        sel = SEL_W'(n);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding/hazard unit: per-register age/latency scoreboard, combinational
// stall, registered EX forwarding selects. Optional FWD_STALL_CNT_EN adds stall_cnt.
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 2,
  parameter int SEL_W    = $clog2(NUM_FWD + 1),
  parameter int LAT_W    = $clog2(NUM_FWD + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_valid,
  input  logic                        issue_we,
  input  logic [ADDR_W-1:0]           issue_rd,
  input  logic [LAT_W-1:0]            issue_lat,
  input  logic                        id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]          id_rs_used,
  input  logic                        flush,
  output logic                        stall,
  output logic [NUM_SRC*SEL_W-1:0]    ex_fwd_sel
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_cnt
`endif
);

  sb_entry_t                  sb_q [NUM_REGS];
  sb_entry_t                  sb_d [NUM_REGS];
  logic                       issue_wr;
  logic [FIELD_W-1:0]         issue_lat_c;
  logic [NUM_SRC-1:0]         hazard;
  logic [NUM_SRC*SEL_W-1:0]   sel_all;
  logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel_q;
  logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel_d;

  assign issue_wr    = issue_valid & issue_we & (issue_rd != '0);
  assign issue_lat_c = clamp_lat(FIELD_W'(issue_lat), NUM_FWD);

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      sb_d[r] = sb_q[r];
      if (sb_q[r].valid) begin
        if (sb_q[r].age >= FIELD_W'(NUM_FWD)) begin
          sb_d[r] = '0;
        end else begin
          sb_d[r].age = sb_q[r].age + 1'b1;
        end
      end
      // Flush beats issue; a fresh issue beats retirement of the same rd
      if (flush) begin
        sb_d[r] = '0;
      end else if (issue_wr && issue_rd == ADDR_W'(r)) begin
        sb_d[r] = '{valid: 1'b1, age: FIELD_W'(1), lat: issue_lat_c};
      end
    end
    sb_d[0] = '0;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [ADDR_W-1:0] rs;
    assign rs = id_rs[i*ADDR_W +: ADDR_W];

    fwd_src_resolve #(
      .ADDR_W (ADDR_W),
      .NUM_FWD(NUM_FWD),
      .SEL_W  (SEL_W)
    ) u_resolve (
      .rs     (rs),
      .used   (id_valid & id_rs_used[i]),
      .ent    (sb_q[rs]),
      .iss_hit(issue_wr && issue_rd == rs),
      .iss_lat(issue_lat_c),
      .hazard (hazard[i]),
      .sel    (sel_all[i*SEL_W +: SEL_W])
    );
  end

  assign stall = |hazard;

  always_comb begin
    ex_fwd_sel_d = sel_all;
    if (flush || stall || !id_valid) begin
      ex_fwd_sel_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        sb_q[r] <= '0;
      end
      ex_fwd_sel_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        sb_q[r] <= sb_d[r];
      end
      ex_fwd_sel_q <= ex_fwd_sel_d;
    end
  end

  assign ex_fwd_sel = ex_fwd_sel_q;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard with a timestamp-based reference model.
module tb_fwd_hazard_scoreboard;

  localparam int AW   = 5;
  localparam int NSRC = 2;
  localparam int NFWD = 2;
  localparam int SELW = 2;
  localparam int LATW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 issue_valid;
  logic                 issue_we;
  logic [AW-1:0]        issue_rd;
  logic [LATW-1:0]      issue_lat;
  logic                 id_valid;
  logic [NSRC*AW-1:0]   id_rs;
  logic [NSRC-1:0]      id_rs_used;
  logic                 flush;
  logic                 stall;
  logic [NSRC*SELW-1:0] ex_fwd_sel;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]          stall_cnt;
`endif

  fwd_hazard_scoreboard #(
    .ADDR_W (AW),
    .NUM_SRC(NSRC),
    .NUM_FWD(NFWD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_valid),
    .issue_we   (issue_we),
    .issue_rd   (issue_rd),
    .issue_lat  (issue_lat),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .flush      (flush),
    .stall      (stall),
    .ex_fwd_sel (ex_fwd_sel)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  // Model: cycle index at which each register was last issued, and its clamped latency
  int issue_cyc [32];
  int issue_l   [32];
  int cyc = 0;
  int exp_sel = 0;

  function automatic int clampl(input int l);
    if (l == 0) return 1;
    if (l > NFWD) return NFWD;
    return l;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) issue_cyc[r] = -100;
    exp_sel = 0;
  endtask

  task automatic model_check();
    int  sel_now [NSRC];
    bit  haz;
    bit  have;
    int  rs, a, l, n, age;
    haz = 0;
    for (int i = 0; i < NSRC; i++) begin
      sel_now[i] = 0;
      have = 0;
      a = 0;
      l = 0;
      rs = int'(id_rs[i*AW +: AW]);
      if (id_valid && id_rs_used[i] && rs != 0) begin
        age = cyc - issue_cyc[rs];
        if (issue_valid && issue_we && int'(issue_rd) == rs) begin
          have = 1; a = 0; l = clampl(int'(issue_lat));
        end else if (age >= 1 && age <= NFWD) begin
          have = 1; a = age; l = issue_l[rs];
        end
      end
      if (have) begin
        n = a + 1;
        if (n <= NFWD) begin
          if (n < l) haz = 1;
          else sel_now[i] = n;
        end
      end
    end
    chk("stall", int'(stall), int'(haz));
    chk("ex_fwd_sel", int'(ex_fwd_sel), exp_sel);
    exp_sel = (flush || haz || !id_valid) ? 0 : sel_now[1] * 4 + sel_now[0];
    if (flush) begin
      for (int r = 0; r < 32; r++) issue_cyc[r] = -100;
    end else if (issue_valid && issue_we && issue_rd != '0) begin
      issue_cyc[issue_rd] = cyc;
      issue_l[issue_rd]   = clampl(int'(issue_lat));
    end
    cyc++;
  endtask

  // One cycle: optional reset pulse straddling the edge, drive inputs, check at negedge
  task automatic step(input bit iv, input bit we, input int rd, input int lat,
                      input bit idv, input int rs0, input int rs1, input bit [1:0] used,
                      input bit fl, input bit pr);
    if (pr) begin
      #3 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_clear();
    end else begin
      @(posedge clk);
      #1;
    end
    issue_valid = iv;
    issue_we    = we;
    issue_rd    = AW'(rd);
    issue_lat   = LATW'(lat);
    id_valid    = idv;
    id_rs       = {AW'(rs1), AW'(rs0)};
    id_rs_used  = used;
    flush       = fl;
    @(negedge clk);
    model_check();
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    issue_valid = 0; issue_we = 0; issue_rd = '0; issue_lat = '0;
    id_valid = 0; id_rs = '0; id_rs_used = '0; flush = 0;
    model_clear();
    @(negedge clk); #1;
    chk("reset_stall", int'(stall), 0);
    chk("reset_sel", int'(ex_fwd_sel), 0);
    #2 rst_n = 1'b1;
    idle(2);

    // ALU chain
    step(1, 1, 5, 1, 1, 5, 0, 2'b01, 0, 0);
    chk("alu_stall", int'(stall), 0);
    idle(1);
    chk("alu_sel", int'(ex_fwd_sel), 1);
    idle(2);

    // Load-use
    step(1, 1, 7, 2, 1, 0, 7, 2'b10, 0, 0);
    chk("lu_stall", int'(stall), 1);
    step(0, 0, 0, 0, 1, 0, 7, 2'b10, 0, 0);
    chk("lu_sel_bubble", int'(ex_fwd_sel), 0);
    chk("lu_stall_release", int'(stall), 0);
    idle(1);
    chk("lu_sel", int'(ex_fwd_sel), 8);
    idle(2);

    // Retirement
    step(1, 1, 3, 1, 0, 0, 0, 2'b00, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 3, 0, 2'b01, 0, 0);
    chk("ret_stall", int'(stall), 0);
    step(0, 0, 0, 0, 1, 3, 0, 2'b01, 0, 0);
    chk("ret_sel", int'(ex_fwd_sel), 0);
    idle(1);
    chk("ret_sel_after", int'(ex_fwd_sel), 0);
    idle(1);

    // Youngest writer wins
    step(1, 1, 4, 2, 0, 0, 0, 2'b00, 0, 0);
    step(1, 1, 4, 1, 1, 4, 0, 2'b01, 0, 0);
    chk("young_stall", int'(stall), 0);
    idle(1);
    chk("young_sel", int'(ex_fwd_sel), 1);
    idle(2);

    // r0 and unused operands
    step(1, 1, 0, 1, 1, 0, 0, 2'b11, 0, 0);
    chk("r0_stall", int'(stall), 0);
    step(1, 1, 8, 2, 1, 8, 8, 2'b00, 0, 0);
    chk("unused_stall", int'(stall), 0);
    chk("r0_sel", int'(ex_fwd_sel), 0);
    idle(1);
    chk("unused_sel", int'(ex_fwd_sel), 0);
    idle(2);

    // Latency clamping: 0 behaves as 1, 3 behaves as NUM_FWD
    step(1, 1, 12, 0, 1, 12, 0, 2'b01, 0, 0);
    chk("clamp0_stall", int'(stall), 0);
    step(1, 1, 13, 3, 1, 0, 13, 2'b10, 0, 0);
    chk("clamp3_stall", int'(stall), 1);
    chk("clamp0_sel", int'(ex_fwd_sel), 1);
    idle(1);
    chk("clamp3_sel", int'(ex_fwd_sel), 0);
    idle(2);

    // Flush with live entries and a same-cycle issue
    step(1, 1, 9, 1, 0, 0, 0, 2'b00, 0, 0);
    step(1, 1, 10, 1, 0, 0, 0, 2'b00, 0, 0);
    step(1, 1, 11, 1, 0, 0, 0, 2'b00, 1, 0);
    step(0, 0, 0, 0, 1, 11, 10, 2'b11, 0, 0);
    chk("flush_stall", int'(stall), 0);
    step(0, 0, 0, 0, 1, 9, 0, 2'b01, 0, 0);
    chk("flush_sel", int'(ex_fwd_sel), 0);
    idle(1);
    chk("flush_sel9", int'(ex_fwd_sel), 0);
    idle(2);

    // Same scenario, asynchronous reset pulse instead of flush
    step(1, 1, 9, 1, 0, 0, 0, 2'b00, 0, 0);
    step(1, 1, 10, 1, 0, 0, 0, 2'b00, 0, 0);
    step(1, 1, 11, 1, 0, 0, 0, 2'b00, 0, 0);
    step(0, 0, 0, 0, 1, 11, 10, 2'b11, 0, 1);
    chk("rst_stall", int'(stall), 0);
    step(0, 0, 0, 0, 1, 9, 0, 2'b01, 0, 0);
    chk("rst_sel", int'(ex_fwd_sel), 0);
    idle(2);

    // Flush while stalling
    step(1, 1, 7, 2, 1, 7, 0, 2'b01, 1, 0);
    step(0, 0, 0, 0, 1, 7, 0, 2'b01, 0, 0);
    chk("flush_stall_sel", int'(ex_fwd_sel), 0);
    idle(2);

    // Pseudo-random traffic on a few registers, checked by the model only
    for (int k = 0; k < 60; k++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
           bit'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
           2'($urandom_range(0, 3)), bit'($urandom_range(0, 9) == 0), 0);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
